// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - shared widths, complex sample type and analysis FSM states
package fas_pkg;

  localparam int FFT_POINTS = 16;
  localparam int SAMPLE_W   = 16;
  localparam int MAG_W      = 32;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } ana_state_t;

endpackage

// File: rtl/fas_mag_sq.sv
// rtl/fas_mag_sq.sv - one lane of squared magnitude, re*re + im*im
module fas_mag_sq
  import fas_pkg::*;
(
  input  cplx_t              d,
  output logic [MAG_W-1:0]   mag
);

  logic signed [2*SAMPLE_W-1:0] re_sq;
  logic signed [2*SAMPLE_W-1:0] im_sq;

  assign re_sq = d.re * d.re;
  assign im_sq = d.im * d.im;

  // Each square is at most 2^30, so the unsigned sum peaks at exactly 2^31.
  assign mag = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fas_analysis.sv
// rtl/fas_analysis.sv - peak-bin search over one 16-point FFT frame, 4 lanes per cycle
module fas_analysis
  import fas_pkg::*;
#(
  parameter int POINTS = FFT_POINTS,
  parameter int LANES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq
);

  localparam int GROUPS = POINTS / LANES;
  localparam int GRP_W  = $clog2(GROUPS);
  localparam int LANE_W = $clog2(LANES);
  localparam int IDX_W  = $clog2(POINTS);

  cplx_t fft_in [POINTS];
  cplx_t frame_q [POINTS];
  cplx_t frame_d [POINTS];

  ana_state_t         state_q, state_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_last_q, s1_last_d;
  logic [GRP_W-1:0]   s1_grp_q, s1_grp_d;
  logic [MAG_W-1:0]   s1_mag_q [LANES];
  logic [MAG_W-1:0]   s1_mag_d [LANES];
  logic               s2_last_q, s2_last_d;
  logic [MAG_W-1:0]   best_mag_q, best_mag_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   freq_q, freq_d;

  logic [MAG_W-1:0]   lane_mag [LANES];

  assign fft_in[0]  = fft_d0;
  assign fft_in[1]  = fft_d1;
  assign fft_in[2]  = fft_d2;
  assign fft_in[3]  = fft_d3;
  assign fft_in[4]  = fft_d4;
  assign fft_in[5]  = fft_d5;
  assign fft_in[6]  = fft_d6;
  assign fft_in[7]  = fft_d7;
  assign fft_in[8]  = fft_d8;
  assign fft_in[9]  = fft_d9;
  assign fft_in[10] = fft_d10;
  assign fft_in[11] = fft_d11;
  assign fft_in[12] = fft_d12;
  assign fft_in[13] = fft_d13;
  assign fft_in[14] = fft_d14;
  assign fft_in[15] = fft_d15;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fas_mag_sq u_mag (
      .d   (frame_q[{grp_q, LANE_W'(g)}]),
      .mag (lane_mag[g])
    );
  end

  // Compare tree: the right-hand operand wins only when strictly larger, so
  // equal magnitudes always resolve to the lower lane.
  logic               sel01, sel23, sel_top;
  logic [MAG_W-1:0]   mag01, mag23, grp_mag;
  logic [LANE_W-1:0]  lane01, lane23, grp_lane;

  always_comb begin
    sel01    = s1_mag_q[1] > s1_mag_q[0];
    mag01    = sel01 ? s1_mag_q[1] : s1_mag_q[0];
    lane01   = sel01 ? LANE_W'(1) : LANE_W'(0);
    sel23    = s1_mag_q[3] > s1_mag_q[2];
    mag23    = sel23 ? s1_mag_q[3] : s1_mag_q[2];
    lane23   = sel23 ? LANE_W'(3) : LANE_W'(2);
    sel_top  = mag23 > mag01;
    grp_mag  = sel_top ? mag23 : mag01;
    grp_lane = sel_top ? lane23 : lane01;
  end

  always_comb begin
    frame_d    = frame_q;
    state_d    = state_q;
    grp_d      = grp_q;
    s1_valid_d = 1'b0;
    s1_last_d  = 1'b0;
    s1_grp_d   = grp_q;
    s1_mag_d   = lane_mag;
    s2_last_d  = 1'b0;
    best_mag_d = best_mag_q;
    best_idx_d = best_idx_q;
    done_d     = 1'b0;
    freq_d     = freq_q;

    if (state_q == SCAN) begin
      s1_valid_d = 1'b1;
      s1_last_d  = (grp_q == GRP_W'(GROUPS - 1));
      grp_d      = grp_q + 1'b1;
      if (grp_q == GRP_W'(GROUPS - 1)) begin
        state_d = REPORT;
      end
    end

    if (s1_valid_q) begin
      s2_last_d = s1_last_q;
      if (grp_mag > best_mag_q) begin
        best_mag_d = grp_mag;
        best_idx_d = {s1_grp_q, grp_lane};
      end
    end

    if (state_q == REPORT && s2_last_q) begin
      done_d  = 1'b1;
      freq_d  = best_idx_q;
      state_d = IDLE;
    end

    // A new frame overrides everything except the report computed above;
    // clearing the pipeline valids keeps stale groups out of the new search.
    if (fft_valid) begin
      frame_d    = fft_in;
      grp_d      = '0;
      best_mag_d = '0;
      best_idx_d = '0;
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
      s2_last_d  = 1'b0;
      state_d    = SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grp_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      best_mag_q <= '0;
      best_idx_q <= '0;
      done_q     <= 1'b0;
      freq_q     <= '0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s2_last_q  <= s2_last_d;
      best_mag_q <= best_mag_d;
      best_idx_q <= best_idx_d;
      done_q     <= done_d;
      freq_q     <= freq_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q  <= frame_d;
    s1_grp_q <= s1_grp_d;
    s1_mag_q <= s1_mag_d;
  end

  assign done = done_q;
  assign freq = freq_q;

endmodule

// File: tb/tb_fas_analysis.sv
// tb/tb_fas_analysis.sv - randomized and directed frames against an argmax reference model
module tb_fas_analysis;

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic [31:0] fd [16];
  logic        done;
  logic [3:0]  freq;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          done_cyc [$];
  logic [3:0]  done_frq [$];

  always #5 clk = ~clk;

  fas_analysis dut (
    .clk       (clk),
    .rst       (rst),
    .fft_valid (fft_valid),
    .fft_d0    (fd[0]),
    .fft_d1    (fd[1]),
    .fft_d2    (fd[2]),
    .fft_d3    (fd[3]),
    .fft_d4    (fd[4]),
    .fft_d5    (fd[5]),
    .fft_d6    (fd[6]),
    .fft_d7    (fd[7]),
    .fft_d8    (fd[8]),
    .fft_d9    (fd[9]),
    .fft_d10   (fd[10]),
    .fft_d11   (fd[11]),
    .fft_d12   (fd[12]),
    .fft_d13   (fd[13]),
    .fft_d14   (fd[14]),
    .fft_d15   (fd[15]),
    .done      (done),
    .freq      (freq)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_frq.push_back(freq);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pt(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  // Reference: compute every magnitude, find the maximum, report its first occurrence.
  function automatic int ref_peak(input logic [31:0] f [16]);
    longint mags [16];
    longint mx;
    int     re, im;
    mx = 0;
    for (int i = 0; i < 16; i++) begin
      re      = int'($signed(f[i][31:16]));
      im      = int'($signed(f[i][15:0]));
      mags[i] = longint'(re) * re + longint'(im) * im;
      if (mags[i] > mx) mx = mags[i];
    end
    for (int i = 0; i < 16; i++) begin
      if (mags[i] == mx) return i;
    end
    return -1;
  endfunction

  task automatic make_peak_frame(input int peak, output logic [31:0] f [16]);
    for (int i = 0; i < 16; i++) begin
      f[i] = pt(int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3);
    end
    f[peak] = pt(1024, -512);
  endtask

  // Called just after a negedge; capture happens at the following posedge.
  task automatic drive_frame(input logic [31:0] f [16], output int t0);
    for (int i = 0; i < 16; i++) fd[i] = f[i];
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic clear_log();
    done_cyc.delete();
    done_frq.delete();
  endtask

  task automatic run_frame(input string tag, input logic [31:0] f [16], input int exp_freq);
    int t0;
    clear_log();
    drive_frame(f, t0);
    repeat (12) @(negedge clk);
    check_eq({tag, "_pulses"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      check_eq({tag, "_latency"}, done_cyc[0] - t0, 6);
      check_eq({tag, "_freq"}, done_frq[0], exp_freq);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] fa [16];
    logic [31:0] fb [16];
    int t0, dummy;

    rst       = 1'b1;
    fft_valid = 1'b0;
    for (int i = 0; i < 16; i++) fd[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_done", done, 0);
    check_eq("reset_freq", freq, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_done", done, 0);
    check_eq("idle_freq", freq, 0);

    for (int i = 0; i < 16; i++) fa[i] = '0;
    run_frame("zeros", fa, 0);

    for (int i = 0; i < 16; i++) fa[i] = pt(1, 1);
    fa[9] = 32'h0300_0400;
    run_frame("peak9", fa, 9);

    for (int i = 0; i < 16; i++) fa[i] = '0;
    fa[3]  = 32'h0200_FE00;
    fa[12] = 32'h0200_FE00;
    run_frame("tie3_12", fa, 3);

    for (int i = 0; i < 16; i++) fa[i] = '0;
    fa[0]  = 32'h7FFF_7FFF;
    fa[15] = 32'h8000_8000;
    run_frame("extreme", fa, 15);

    for (int n = 0; n < 30; n++) begin
      case (n % 3)
        0: for (int i = 0; i < 16; i++) fa[i] = $urandom;
        1: for (int i = 0; i < 16; i++) fa[i] = pt(int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 4)) - 2);
        default: make_peak_frame(int'($urandom_range(0, 15)), fa);
      endcase
      run_frame($sformatf("rand%0d", n), fa, ref_peak(fa));
    end

    // Back-to-back frames 16 cycles apart.
    clear_log();
    make_peak_frame(5, fa);
    make_peak_frame(10, fb);
    drive_frame(fa, t0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k >= 7) check_eq("b2b_hold", freq, 5);
    end
    drive_frame(fb, dummy);
    repeat (12) @(negedge clk);
    check_eq("b2b_pulses", done_cyc.size(), 2);
    if (done_cyc.size() > 1) begin
      check_eq("b2b_first_lat", done_cyc[0] - t0, 6);
      check_eq("b2b_spacing", done_cyc[1] - done_cyc[0], 16);
      check_eq("b2b_freq_a", done_frq[0], 5);
      check_eq("b2b_freq_b", done_frq[1], 10);
    end
    repeat (4) @(negedge clk);

    // New frame on the same edge as the old frame's report.
    clear_log();
    make_peak_frame(4, fa);
    make_peak_frame(13, fb);
    drive_frame(fa, t0);
    repeat (5) @(negedge clk);
    drive_frame(fb, dummy);
    repeat (12) @(negedge clk);
    check_eq("overlap_pulses", done_cyc.size(), 2);
    if (done_cyc.size() > 1) begin
      check_eq("overlap_lat_a", done_cyc[0] - t0, 6);
      check_eq("overlap_freq_a", done_frq[0], 4);
      check_eq("overlap_lat_b", done_cyc[1] - t0, 12);
      check_eq("overlap_freq_b", done_frq[1], 13);
    end
    repeat (4) @(negedge clk);

    // Restart at T+2 discards the first frame.
    clear_log();
    make_peak_frame(2, fa);
    make_peak_frame(7, fb);
    drive_frame(fa, t0);
    @(negedge clk);
    drive_frame(fb, dummy);
    repeat (12) @(negedge clk);
    check_eq("abort_pulses", done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      check_eq("abort_lat", done_cyc[0] - t0, 8);
      check_eq("abort_freq", done_frq[0], 7);
    end
    repeat (4) @(negedge clk);

    // Reset sampled at T+3 abandons the frame.
    clear_log();
    make_peak_frame(11, fa);
    drive_frame(fa, t0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("rst_pulses", done_cyc.size(), 0);
    check_eq("rst_freq", freq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
